// File: rtl/uart_rx_frame_parser.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_parser
//   Framer for the UART receive byte stream. It hunts for a HEAD0/HEAD1
//   header, captures a length-prefixed payload into a local buffer and
//   verifies an 8-bit additive checksum (LEN + payload, mod 256). Only
//   verified payloads are released on a valid/ready stream with a last flag.
//   Malformed frames are discarded and reported on o_err/o_err_code.
//
//   Frame: HEAD0, HEAD1, LEN, LEN payload bytes, CHK
//
// Ports
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_user_rx_data     received byte from the UART driver
//   i_user_rx_valid    one-cycle strobe per byte (no backpressure)
//   o_frame_data       payload byte being released
//   o_frame_valid      payload byte available
//   o_frame_last       current byte is the final payload byte
//   i_frame_ready      user accepts the current byte
//   o_frame_len        length of the frame being released
//   o_err              one-cycle pulse when a frame is discarded
//   o_err_code         1 = bad length, 2 = checksum, 3 = timeout (held)
//   o_drop             one-cycle pulse when a byte arrives during release
//
// Configuration
//   FRAME_TIMEOUT_EN   when defined, a frame stalled for P_TIMEOUT_CYC cycles
//                      in LEN/PAYLOAD/CHECK is discarded with code 3.
// ---------------------------------------------------------------------------
module uart_rx_frame_parser #(
  parameter int unsigned                P_DATA_WIDTH  = 8,
  parameter logic [P_DATA_WIDTH-1:0]    P_HEAD0       = 8'h55,
  parameter logic [P_DATA_WIDTH-1:0]    P_HEAD1       = 8'hAA,
  parameter int unsigned                P_MAX_LEN     = 16,
  parameter int unsigned                P_TIMEOUT_CYC = 20000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [P_DATA_WIDTH-1:0] i_user_rx_data,
  input  logic                    i_user_rx_valid,
  output logic [P_DATA_WIDTH-1:0] o_frame_data,
  output logic                    o_frame_valid,
  output logic                    o_frame_last,
  input  logic                    i_frame_ready,
  output logic [7:0]              o_frame_len,
  output logic                    o_err,
  output logic [1:0]              o_err_code,
  output logic                    o_drop
);

  localparam int unsigned PW = $clog2(P_MAX_LEN + 1);
  localparam int unsigned IW = (P_MAX_LEN > 1) ? $clog2(P_MAX_LEN) : 1;

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;

  typedef enum logic [2:0] {
    S_HUNT0   = 3'd0,
    S_HUNT1   = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHECK   = 3'd4,
    S_DRAIN   = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              chk_q, chk_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [P_DATA_WIDTH-1:0] frame_data_q, frame_data_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    frame_last_q, frame_last_d;
  logic [7:0]              frame_len_q, frame_len_d;
  logic                    err_q, err_d;
  logic [1:0]              err_code_q, err_code_d;
  logic                    drop_q, drop_d;
  logic                    buf_we_c;
  logic [7:0]              rx_byte_c;

  logic [P_DATA_WIDTH-1:0] buf_q [P_MAX_LEN];

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned CW = $clog2(P_TIMEOUT_CYC + 1);
  localparam logic [1:0]  ERR_TMO = 2'd3;
  // Counts cycles since the last strobe; 1 in the cycle right after a strobe.
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic          tmo_active_c;
`endif

  assign rx_byte_c = 8'(i_user_rx_data);

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    chk_d         = chk_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    frame_last_d  = frame_last_q;
    frame_len_d   = frame_len_q;
    err_d         = 1'b0;
    err_code_d    = err_code_q;
    drop_d        = 1'b0;
    buf_we_c      = 1'b0;

    unique case (state_q)
      S_HUNT0: begin
        if (i_user_rx_valid && (i_user_rx_data == P_HEAD0)) begin
          state_d = S_HUNT1;
        end
      end

      S_HUNT1: begin
        if (i_user_rx_valid) begin
          if (i_user_rx_data == P_HEAD1) begin
            state_d = S_LEN;
          end else if (i_user_rx_data != P_HEAD0) begin
            state_d = S_HUNT0;
          end
        end
      end

      S_LEN: begin
        if (i_user_rx_valid) begin
          if ((rx_byte_c == 8'd0) || (rx_byte_c > 8'(P_MAX_LEN))) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = S_HUNT0;
          end else begin
            len_d    = rx_byte_c;
            chk_d    = rx_byte_c;
            wr_ptr_d = '0;
            state_d  = S_PAYLOAD;
          end
        end
      end

      S_PAYLOAD: begin
        if (i_user_rx_valid) begin
          buf_we_c = 1'b1;
          chk_d    = chk_q + rx_byte_c;
          wr_ptr_d = wr_ptr_q + PW'(1);
          if ((8'(wr_ptr_q) + 8'd1) == len_q) begin
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        if (i_user_rx_valid) begin
          if (rx_byte_c == chk_q) begin
            // Present byte 0 in the cycle right after the CHK strobe.
            frame_data_d  = buf_q[IW'(0)];
            frame_valid_d = 1'b1;
            frame_last_d  = (len_q == 8'd1);
            frame_len_d   = len_q;
            rd_ptr_d      = PW'(1);
            state_d       = S_DRAIN;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
            state_d    = S_HUNT0;
          end
        end
      end

      S_DRAIN: begin
        // Input bytes cannot be stored while the buffer is being released.
        if (i_user_rx_valid) begin
          drop_d = 1'b1;
        end
        if (frame_valid_q && i_frame_ready) begin
          if (frame_last_q) begin
            frame_valid_d = 1'b0;
            frame_last_d  = 1'b0;
            state_d       = S_HUNT0;
          end else begin
            frame_data_d = buf_q[IW'(rd_ptr_q)];
            frame_last_d = ((8'(rd_ptr_q) + 8'd1) == len_q);
            rd_ptr_d     = rd_ptr_q + PW'(1);
          end
        end
      end

      default: begin
        state_d = S_HUNT0;
      end
    endcase

`ifdef FRAME_TIMEOUT_EN
    tmo_active_c = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    if (i_user_rx_valid) begin
      idle_cnt_d = CW'(1);
    end else if (tmo_active_c) begin
      idle_cnt_d = idle_cnt_q + CW'(1);
    end else begin
      idle_cnt_d = '0;
    end
    // Abandon a frame once P_TIMEOUT_CYC cycles pass without a strobe.
    if (tmo_active_c && !i_user_rx_valid && (idle_cnt_q == CW'(P_TIMEOUT_CYC - 1))) begin
      err_d      = 1'b1;
      err_code_d = ERR_TMO;
      state_d    = S_HUNT0;
    end
`endif
  end

  // Control and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= S_HUNT0;
      len_q         <= '0;
      chk_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_last_q  <= 1'b0;
      frame_len_q   <= '0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      chk_q         <= chk_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_last_q  <= frame_last_d;
      frame_len_q   <= frame_len_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      drop_q        <= drop_d;
    end
  end

`ifdef FRAME_TIMEOUT_EN
  // Inter-byte idle counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`endif

  // Payload buffer; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (buf_we_c) begin
      buf_q[IW'(wr_ptr_q)] <= i_user_rx_data;
    end
  end

  assign o_frame_data  = frame_data_q;
  assign o_frame_valid = frame_valid_q;
  assign o_frame_last  = frame_last_q;
  assign o_frame_len   = frame_len_q;
  assign o_err         = err_q;
  assign o_err_code    = err_code_q;
  assign o_drop        = drop_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
module tb_uart_rx_frame_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       ready;
  logic [7:0] o_frame_data;
  logic       o_frame_valid;
  logic       o_frame_last;
  logic [7:0] o_frame_len;
  logic       o_err;
  logic [1:0] o_err_code;
  logic       o_drop;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt = 0;
  int drop_cnt  = 0;

  uart_rx_frame_parser #(
    .P_DATA_WIDTH (8),
    .P_HEAD0      (8'h55),
    .P_HEAD1      (8'hAA),
    .P_MAX_LEN    (16),
    .P_TIMEOUT_CYC(50)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_user_rx_data (rx_data),
    .i_user_rx_valid(rx_valid),
    .o_frame_data   (o_frame_data),
    .o_frame_valid  (o_frame_valid),
    .o_frame_last   (o_frame_last),
    .i_frame_ready  (ready),
    .o_frame_len    (o_frame_len),
    .o_err          (o_err),
    .o_err_code     (o_err_code),
    .o_drop         (o_drop)
  );

  always #5 clk = ~clk;

  // Event counters sampled on the active edge (pre-update values).
  always @(posedge clk) begin
    if (o_frame_valid) valid_cnt <= valid_cnt + 1;
    if (o_drop) drop_cnt <= drop_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Sends 55 AA 03 11 22 33 69 with ready high and checks the release.
  task automatic run_good_frame(input string tag);
    drive(8'h55); drive(8'hAA); drive(8'h03);
    drive(8'h11); drive(8'h22); drive(8'h33); drive(8'h69);
    idle();
    n_checks++; if ({o_frame_valid, o_frame_last, o_frame_data} !== {1'b1, 1'b0, 8'h11}) begin n_fail++; $display("FAIL %s_b0: got v%b l%b %h exp v1 l0 11", tag, o_frame_valid, o_frame_last, o_frame_data); end
    n_checks++; if ({o_frame_len, o_err} !== {8'd3, 1'b0}) begin n_fail++; $display("FAIL %s_len: got len %0d err %b exp len 3 err 0", tag, o_frame_len, o_err); end
    @(negedge clk);
    n_checks++; if ({o_frame_valid, o_frame_last, o_frame_data} !== {1'b1, 1'b0, 8'h22}) begin n_fail++; $display("FAIL %s_b1: got v%b l%b %h exp v1 l0 22", tag, o_frame_valid, o_frame_last, o_frame_data); end
    @(negedge clk);
    n_checks++; if ({o_frame_valid, o_frame_last, o_frame_data} !== {1'b1, 1'b1, 8'h33}) begin n_fail++; $display("FAIL %s_b2: got v%b l%b %h exp v1 l1 33", tag, o_frame_valid, o_frame_last, o_frame_data); end
    @(negedge clk);
    n_checks++; if (o_frame_valid !== 1'b0) begin n_fail++; $display("FAIL %s_end: got valid %b exp 0", tag, o_frame_valid); end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if ({o_frame_valid, o_frame_last, o_err, o_drop, o_frame_data, o_frame_len, o_err_code} !== 22'd0) begin n_fail++; $display("FAIL reset_outs: got v%b l%b e%b d%b data %h len %h code %0d exp all 0", o_frame_valid, o_frame_last, o_err, o_drop, o_frame_data, o_frame_len, o_err_code); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    run_good_frame("good");
  endtask

  task automatic test_checksum_err();
    int vs;
    vs = valid_cnt;
    drive(8'h55); drive(8'hAA); drive(8'h02); drive(8'h01); drive(8'h02); drive(8'h00);
    idle();
    n_checks++; if ({o_err, o_err_code} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL chk_err: got err %b code %0d exp err 1 code 2", o_err, o_err_code); end
    @(negedge clk);
    n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL chk_pulse: got err %b exp 0", o_err); end
    repeat (3) @(negedge clk);
    n_checks++; if (valid_cnt != vs) begin n_fail++; $display("FAIL chk_novalid: got %0d valid cycles exp 0", valid_cnt - vs); end
    run_good_frame("chk_next");
  endtask

  task automatic test_bad_length();
    drive(8'h55); drive(8'hAA); drive(8'h00);
    idle();
    n_checks++; if ({o_err, o_err_code} !== {1'b1, 2'd1}) begin n_fail++; $display("FAIL len0: got err %b code %0d exp err 1 code 1", o_err, o_err_code); end
    @(negedge clk);
    n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL len0_pulse: got err %b exp 0", o_err); end
    drive(8'h55); drive(8'hAA); drive(8'h11);
    idle();
    n_checks++; if ({o_err, o_err_code} !== {1'b1, 2'd1}) begin n_fail++; $display("FAIL len17: got err %b code %0d exp err 1 code 1", o_err, o_err_code); end
    repeat (2) @(negedge clk);
    n_checks++; if ({o_err, o_err_code} !== {1'b0, 2'd1}) begin n_fail++; $display("FAIL len_hold: got err %b code %0d exp err 0 code 1", o_err, o_err_code); end
    run_good_frame("len_next");
  endtask

  task automatic test_resync_backpressure();
    int ds;
    ds = drop_cnt;
    ready = 1'b0;
    drive(8'h55); drive(8'h55); drive(8'hAA); drive(8'h01); drive(8'h7F); drive(8'h80);
    idle();
    n_checks++; if ({o_frame_valid, o_frame_last, o_frame_data, o_frame_len} !== {1'b1, 1'b1, 8'h7F, 8'd1}) begin n_fail++; $display("FAIL bp_first: got v%b l%b %h len %0d exp v1 l1 7F len 1", o_frame_valid, o_frame_last, o_frame_data, o_frame_len); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      rx_data  = 8'h55;
      rx_valid = (k <= 3);
      if (k == 5) ready = 1'b1;
      n_checks++; if ({o_frame_valid, o_frame_last, o_frame_data} !== {1'b1, 1'b1, 8'h7F}) begin n_fail++; $display("FAIL bp_hold%0d: got v%b l%b %h exp v1 l1 7F", k, o_frame_valid, o_frame_last, o_frame_data); end
    end
    @(negedge clk);
    n_checks++; if (o_frame_valid !== 1'b0) begin n_fail++; $display("FAIL bp_accept: got valid %b exp 0", o_frame_valid); end
    repeat (2) @(negedge clk);
    n_checks++; if ((drop_cnt - ds) != 3) begin n_fail++; $display("FAIL bp_drops: got %0d exp 3", drop_cnt - ds); end
    run_good_frame("bp_next");
  endtask

  task automatic test_back_to_back();
    int ds;
    ds = drop_cnt;
    drive(8'h55); drive(8'hAA); drive(8'h02); drive(8'h10); drive(8'h20); drive(8'h32);
    @(negedge clk);
    rx_data = 8'hEE; rx_valid = 1'b1;
    n_checks++; if ({o_frame_valid, o_frame_last, o_frame_data, o_frame_len} !== {1'b1, 1'b0, 8'h10, 8'd2}) begin n_fail++; $display("FAIL b2b_b0: got v%b l%b %h len %0d exp v1 l0 10 len 2", o_frame_valid, o_frame_last, o_frame_data, o_frame_len); end
    @(negedge clk);
    rx_data = 8'h99; rx_valid = 1'b1;
    n_checks++; if ({o_frame_valid, o_frame_last, o_frame_data} !== {1'b1, 1'b1, 8'h20}) begin n_fail++; $display("FAIL b2b_b1: got v%b l%b %h exp v1 l1 20", o_frame_valid, o_frame_last, o_frame_data); end
    @(negedge clk);
    rx_data = 8'h55; rx_valid = 1'b1;
    n_checks++; if ({o_frame_valid, o_drop} !== {1'b0, 1'b1}) begin n_fail++; $display("FAIL b2b_m1: got valid %b drop %b exp valid 0 drop 1", o_frame_valid, o_drop); end
    drive(8'hAA); drive(8'h01); drive(8'h5A); drive(8'h5B);
    idle();
    n_checks++; if ({o_frame_valid, o_frame_last, o_frame_data, o_frame_len} !== {1'b1, 1'b1, 8'h5A, 8'd1}) begin n_fail++; $display("FAIL b2b_next: got v%b l%b %h len %0d exp v1 l1 5A len 1", o_frame_valid, o_frame_last, o_frame_data, o_frame_len); end
    idle();
    n_checks++; if (o_frame_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got valid %b exp 0", o_frame_valid); end
    n_checks++; if ((drop_cnt - ds) != 2) begin n_fail++; $display("FAIL b2b_drops: got %0d exp 2", drop_cnt - ds); end
  endtask

  task automatic test_timeout();
    int hit;
    int errs;
    hit = 0; errs = 0;
    drive(8'h55); drive(8'hAA); drive(8'h04); drive(8'h01);
`ifdef FRAME_TIMEOUT_EN
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (hit == 0 && o_err === 1'b1) hit = k;
    end
    n_checks++; if (hit != 50) begin n_fail++; $display("FAIL tmo_time: got err at +%0d cycles exp +50", hit); end
    n_checks++; if (o_err_code !== 2'd3) begin n_fail++; $display("FAIL tmo_code: got %0d exp 3", o_err_code); end
    run_good_frame("tmo_next");
`else
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (o_err === 1'b1) errs++;
    end
    n_checks++; if (errs != 0) begin n_fail++; $display("FAIL stall_noerr: got %0d err pulses exp 0", errs); end
    drive(8'h02); drive(8'h03); drive(8'h04); drive(8'h0E);
    idle();
    n_checks++; if ({o_frame_valid, o_frame_data, o_frame_len} !== {1'b1, 8'h01, 8'd4}) begin n_fail++; $display("FAIL stall_rel: got v%b %h len %0d exp v1 01 len 4", o_frame_valid, o_frame_data, o_frame_len); end
    repeat (4) @(negedge clk);
    n_checks++; if (o_frame_valid !== 1'b0) begin n_fail++; $display("FAIL stall_end: got valid %b exp 0", o_frame_valid); end
`endif
  endtask

  task automatic test_reset_mid();
    drive(8'h55); drive(8'hAA); drive(8'h03); drive(8'h11);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if ({o_frame_valid, o_frame_last, o_err, o_drop, o_frame_data, o_frame_len, o_err_code} !== 22'd0) begin n_fail++; $display("FAIL rst_payload: got v%b l%b e%b d%b data %h len %h code %0d exp all 0", o_frame_valid, o_frame_last, o_err, o_drop, o_frame_data, o_frame_len, o_err_code); end
    @(negedge clk);
    rst = 1'b0;
    run_good_frame("rstp_next");
    ready = 1'b0;
    drive(8'h55); drive(8'hAA); drive(8'h03); drive(8'h11); drive(8'h22); drive(8'h33); drive(8'h69);
    idle();
    n_checks++; if ({o_frame_valid, o_frame_data} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL rst_drain_pre: got v%b %h exp v1 11", o_frame_valid, o_frame_data); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if ({o_frame_valid, o_frame_last, o_err, o_drop, o_frame_data, o_frame_len, o_err_code} !== 22'd0) begin n_fail++; $display("FAIL rst_drain: got v%b l%b e%b d%b data %h len %h code %0d exp all 0", o_frame_valid, o_frame_last, o_err, o_drop, o_frame_data, o_frame_len, o_err_code); end
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;
    run_good_frame("rstd_next");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_checksum_err();
    test_bad_length();
    test_resync_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_parser.md
# uart_rx_frame_parser

Byte-stream framer that sits directly downstream of the UART driver's receive user interface and consumes its `o_user_rx_data`/`o_user_rx_valid` byte strobes. It hunts for a two-byte header, captures a length-prefixed payload into an internal buffer and checks an 8-bit additive checksum. Only verified payloads are released to the user side over a valid/ready stream with a last flag; malformed frames are discarded and reported.

## Interface
- `P_DATA_WIDTH`, 8 — byte width; must match the driver's data width.
- `P_HEAD0`, 8'h55 — first header byte.
- `P_HEAD1`, 8'hAA — second header byte.
- `P_MAX_LEN`, 16 — maximum payload length in bytes; legal range 1..255.
- `P_TIMEOUT_CYC`, 20000 — inter-byte timeout in clock cycles (only with `FRAME_TIMEOUT_EN`).

Ports:
- `i_clk` input 1 — the single clock; the same domain as the driver's user interface.
- `i_rst` input 1 — asynchronous, active-high reset.
- `i_user_rx_data` input P_DATA_WIDTH — received byte.
- `i_user_rx_valid` input 1 — one-cycle strobe per received byte; no backpressure.
- `o_frame_data` output P_DATA_WIDTH — payload byte.
- `o_frame_valid` output 1 — payload byte available.
- `o_frame_last` output 1 — the current byte is the final payload byte.
- `i_frame_ready` input 1 — user accepts the current byte.
- `o_frame_len` output 8 — length of the frame being released; held while `o_frame_valid` is high.
- `o_err` output 1 — one-cycle pulse when a frame is discarded.
- `o_err_code` output 2 — cause of the discard: 1 = bad length, 2 = checksum, 3 = timeout. Held until the next error.
- `o_drop` output 1 — one-cycle pulse when an input byte is discarded during DRAIN.

## Operation
- Frame format: HEAD0, HEAD1, LEN, LEN payload bytes, CHK.
- CHK = (LEN + sum of payload) mod 256.
- States and transitions:
  - HUNT0: a byte equal to HEAD0 moves to HUNT1; any other byte is ignored.
  - HUNT1: HEAD1 moves to LEN. HEAD0 stays in HUNT1 (resync). Any other byte returns to HUNT0.
  - LEN: a value of 0 or greater than P_MAX_LEN pulses `o_err` with code 1 and returns to HUNT0. Otherwise the parser latches LEN, seeds the checksum with LEN, clears the write pointer and moves to PAYLOAD.
  - PAYLOAD: each byte is written to `buf[wr_ptr]`, `wr_ptr` increments and the byte is added to the checksum. After LEN bytes the parser moves to CHECK.
  - CHECK: on the next byte, a match moves to DRAIN. A mismatch pulses `o_err` with code 2 and returns to HUNT0.
  - DRAIN: buffered bytes 0..LEN-1 are presented in order. After the handshake on the last byte, the parser returns to HUNT0.
- Buffer: P_MAX_LEN × P_DATA_WIDTH register array.
- Pointer width is $clog2(P_MAX_LEN+1). The checksum accumulator is 8 bits and wraps modulo 256.
- During DRAIN, input bytes are not stored. Each one pulses `o_drop`, and header hunting does not run.
- Reset mid-frame or mid-drain: the parser returns to HUNT0 immediately and buffer contents are abandoned.

## Timing
- Reset values:
  - `o_frame_valid`, `o_frame_last`, `o_err`, `o_drop` = 0.
  - `o_frame_data` = 0, `o_frame_len` = 0, `o_err_code` = 0.
  - State = HUNT0.
- Every input byte is consumed in its own strobe cycle. Back-to-back strobes on consecutive cycles are supported in every state.
- Release latency: if the CHK strobe arrives in cycle N, `o_frame_valid` rises in cycle N+1 with byte 0. `o_frame_last` is high in N+1 when LEN = 1.
- Stream handshake:
  - A transfer occurs in any cycle where `o_frame_valid` and `i_frame_ready` are both high.
  - The next byte is presented in the following cycle, so throughput is 1 byte per cycle.
  - `o_frame_data`, `o_frame_last` and `o_frame_valid` remain stable while `o_frame_valid` is high and `i_frame_ready` is low.
- After the last transfer in cycle M, `o_frame_valid` is low in M+1 and the state is HUNT0. A byte strobed in M+1 is parsed normally.
- An input strobe in the same cycle as the last transfer still counts as a DRAIN drop.
- `o_err` and `o_drop` are registered and pulse in the cycle after the offending strobe.

## Configuration
- `FRAME_TIMEOUT_EN` defined:
  - An idle counter is cleared on every strobe while the state is LEN, PAYLOAD or CHECK.
  - When the counter reaches P_TIMEOUT_CYC with no strobe, the parser pulses `o_err` with code 3 and returns to HUNT0.
  - The counter is inactive in HUNT0, HUNT1 and DRAIN.
- `FRAME_TIMEOUT_EN` undefined: there is no counter, a stalled frame waits indefinitely, and code 3 is never produced.

## Test plan
- Good frame: stream 55 AA 03 11 22 33 69 with `i_frame_ready` = 1.
  - Expect 11, 22, 33 on consecutive cycles starting at N+1; `o_frame_last` on 33; `o_frame_len` = 3; no `o_err`.
- Checksum error: stream 55 AA 02 01 02 00.
  - Expect an `o_err` pulse with code 2, `o_frame_valid` never high, and the next good frame parsed correctly.
- Bad length: send LEN = 00, then separately LEN = P_MAX_LEN+1 (17).
  - Expect an `o_err` pulse with code 1 for each, and return to HUNT0.
- Resync and backpressure:
  - Stream 55 55 AA 01 7F 80 and hold `i_frame_ready` low for 5 cycles.
  - Expect 7F to be held stable with `o_frame_last` = 1, and accepted on the first ready cycle.
  - Feed 3 bytes during the stall; expect 3 `o_drop` pulses.
- Timeout (`FRAME_TIMEOUT_EN`, P_TIMEOUT_CYC = 50):
  - Stream 55 AA 04 01 and then stop.
  - Expect an `o_err` pulse with code 3 exactly 50 cycles after the last strobe; a following good frame is released.
- Reset mid-operation: assert `i_rst` during PAYLOAD, and separately during DRAIN.
  - Expect all outputs 0 immediately (asynchronous), state HUNT0, and a subsequent good frame parsed normally.
